cnn_frame_downscaler: RTL and testbench



---
 rtl/cnn_ds_pkg.sv | 25 ++
 rtl/cnn_frame_downscaler_reduce.sv | 41 ++++
 rtl/cnn_frame_downscaler.sv | 234 +++++++++++++++++++++++
 tb/tb_cnn_frame_downscaler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_ds_pkg.sv
// rtl/cnn_ds_pkg.sv - shared types and geometry helpers for the frame downscaler
package cnn_ds_pkg;

  typedef enum logic [1:0] {
    MODE_AVG = 2'd0,
    MODE_MAX = 2'd1,
    MODE_BIN = 2'd2,
    MODE_RSV = 2'd3
  } ds_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ds_state_e;

  // Lane must hold the sum of a full block without overflow.
  function automatic int acc_width(input int pix_w, input int blk_w, input int blk_h);
    return pix_w + $clog2(blk_w * blk_h);
  endfunction

  function automatic int window_offset(input int full, input int count, input int blk);
    return (full - count * blk) / 2;
  endfunction

endpackage

// File: rtl/cnn_frame_downscaler_reduce.sv
// rtl/cnn_frame_downscaler_reduce.sv - combinational block finalizer (avg / max / binarised avg)
module ds_block_reduce
  import cnn_ds_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int ACC_W = 14,
  parameter int LOG_N = 6
) (
  input  logic [ACC_W-1:0] lane_i,
  input  logic             first_i,
  input  logic [PIX_W-1:0] pix_i,
  input  ds_mode_e         mode_i,
  input  logic [PIX_W-1:0] thr_i,
  output logic [PIX_W-1:0] res_o
);

  localparam int SW = ACC_W + 1;
  localparam logic [SW-1:0] HALF = SW'((1 << LOG_N) >> 1);
  localparam logic [SW-1:0] PIX_MAX = SW'({PIX_W{1'b1}});

  logic [SW-1:0]    sum_w;
  logic [SW-1:0]    avg_w;
  logic [PIX_W-1:0] avg_pix_w;
  logic [PIX_W-1:0] max_w;

  // The completing pixel is folded in here; the lane holds everything before it.
  assign sum_w     = first_i ? SW'(pix_i) : ({1'b0, lane_i} + SW'(pix_i));
  assign avg_w     = (sum_w + HALF) >> LOG_N;
  assign avg_pix_w = (avg_w > PIX_MAX) ? '1 : avg_w[PIX_W-1:0];
  assign max_w     = (first_i || pix_i > lane_i[PIX_W-1:0]) ? pix_i : lane_i[PIX_W-1:0];

  always_comb begin
    res_o = avg_pix_w;
    case (mode_i)
      MODE_MAX: res_o = max_w;
      MODE_BIN: res_o = (avg_pix_w >= thr_i) ? '1 : '0;
      default:  res_o = avg_pix_w;
    endcase
  end

endmodule

// File: rtl/cnn_frame_downscaler.sv
// rtl/cnn_frame_downscaler.sv - streaming centred-window downscaler with display overlay
module cnn_frame_downscaler
  import cnn_ds_pkg::*;
#(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int BLK_W     = 8,
  parameter int BLK_H     = 8,
  parameter int OUT_W     = 28,
  parameter int OUT_H     = 28,
  parameter int PIX_W     = 8,
  parameter int LN_BASE   = 66,
  parameter int LN_STRIDE = 32,
  parameter int LN_AW     = 10
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic             pix_sof,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] bin_thr,
  input  logic             border_en,
  output logic             disp_we,
  output logic [18:0]      disp_addr,
  output logic [PIX_W-1:0] disp_data,
  output logic             ln_we,
  output logic [LN_AW-1:0] ln_addr,
  output logic [PIX_W-1:0] ln_data,
  output logic             data_ready,
  output logic             frame_err
);

  localparam int ACC_W = acc_width(PIX_W, BLK_W, BLK_H);
  localparam int LOG_N = $clog2(BLK_W * BLK_H);
  localparam int LEFT  = window_offset(WIDTH, OUT_W, BLK_W);
  localparam int TOP   = window_offset(HEIGHT, OUT_H, BLK_H);
  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam int BXW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int BYW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] WIN_X0 = XW'(LEFT);
  localparam logic [XW-1:0] WIN_X1 = XW'(LEFT + OUT_W * BLK_W - 1);
  localparam logic [YW-1:0] WIN_Y0 = YW'(TOP);
  localparam logic [YW-1:0] WIN_Y1 = YW'(TOP + OUT_H * BLK_H - 1);
  localparam logic [XW-1:0] BW_X   = XW'(BLK_W);
  localparam logic [YW-1:0] BH_Y   = YW'(BLK_H);

  if (OUT_W * BLK_W > WIDTH) begin : g_chk_w
    $error("cnn_frame_downscaler: OUT_W*BLK_W exceeds WIDTH");
  end
  if (OUT_H * BLK_H > HEIGHT) begin : g_chk_h
    $error("cnn_frame_downscaler: OUT_H*BLK_H exceeds HEIGHT");
  end
  if (((BLK_W * BLK_H) & (BLK_W * BLK_H - 1)) != 0) begin : g_chk_n
    $error("cnn_frame_downscaler: BLK_W*BLK_H must be a power of two");
  end

  ds_state_e        state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic             en_q, en_d;
  ds_mode_e         mode_q, mode_d;
  logic [PIX_W-1:0] thr_q, thr_d;
  logic [ACC_W-1:0] lane_q [OUT_W];

  logic             disp_we_q, disp_we_d;
  logic [18:0]      disp_addr_q, disp_addr_d;
  logic [PIX_W-1:0] disp_data_q, disp_data_d;
  logic             ln_we_q, ln_we_d;
  logic [LN_AW-1:0] ln_addr_q, ln_addr_d;
  logic [PIX_W-1:0] ln_data_q, ln_data_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;

  logic             start, accept, in_win, on_border, blk_first, blk_last, lane_we;
  logic [XW-1:0]    cur_x, rx;
  logic [YW-1:0]    cur_y, ry;
  logic [BXW-1:0]   bx;
  logic [BYW-1:0]   by;
  logic             eff_en;
  ds_mode_e         eff_mode;
  logic [PIX_W-1:0] eff_thr, red_pix;
  logic [ACC_W-1:0] lane_rd, lane_d;

  // An SOF pixel is always pixel (0,0) and carries its own configuration.
  assign start    = pix_valid && pix_sof;
  assign accept   = pix_valid && (pix_sof || state_q == ST_RUN);
  assign cur_x    = start ? '0 : x_q;
  assign cur_y    = start ? '0 : y_q;
  assign eff_en   = start ? enable : en_q;
  assign eff_mode = start ? ds_mode_e'(mode) : mode_q;
  assign eff_thr  = start ? bin_thr : thr_q;

  assign in_win    = (cur_x >= WIN_X0) && (cur_x <= WIN_X1) && (cur_y >= WIN_Y0) && (cur_y <= WIN_Y1);
  assign on_border = in_win && (cur_x == WIN_X0 || cur_x == WIN_X1 || cur_y == WIN_Y0 || cur_y == WIN_Y1);
  assign rx        = cur_x - WIN_X0;
  assign ry        = cur_y - WIN_Y0;
  assign bx        = BXW'(rx / BW_X);
  assign by        = BYW'(ry / BH_Y);
  assign blk_first = ((rx % BW_X) == '0) && ((ry % BH_Y) == '0);
  assign blk_last  = in_win && ((rx % BW_X) == BW_X - XW'(1)) && ((ry % BH_Y) == BH_Y - YW'(1));
  assign lane_we   = accept && in_win;

  assign lane_rd = lane_q[bx];
  always_comb begin
    lane_d = lane_rd + ACC_W'(pix_data);
    if (blk_first) begin
      lane_d = ACC_W'(pix_data);
    end else if (eff_mode == MODE_MAX) begin
      lane_d = (pix_data > lane_rd[PIX_W-1:0]) ? ACC_W'(pix_data) : lane_rd;
    end
  end

  ds_block_reduce #(
    .PIX_W (PIX_W),
    .ACC_W (ACC_W),
    .LOG_N (LOG_N)
  ) u_reduce (
    .lane_i  (lane_rd),
    .first_i (blk_first),
    .pix_i   (pix_data),
    .mode_i  (eff_mode),
    .thr_i   (eff_thr),
    .res_o   (red_pix)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    en_d        = en_q;
    mode_d      = mode_q;
    thr_d       = thr_q;
    disp_we_d   = 1'b0;
    disp_addr_d = disp_addr_q;
    disp_data_d = disp_data_q;
    ln_we_d     = 1'b0;
    ln_addr_d   = ln_addr_q;
    ln_data_d   = ln_data_q;
    ready_d     = 1'b0;
    err_d       = 1'b0;
    if (accept) begin
      state_d     = ST_RUN;
      disp_we_d   = 1'b1;
      disp_addr_d = 19'(cur_y) * 19'(WIDTH) + 19'(cur_x);
      disp_data_d = (border_en && eff_en && on_border) ? '1 : pix_data;
      if (eff_en && blk_last) begin
        ln_we_d   = 1'b1;
        ln_addr_d = LN_AW'(LN_BASE) + LN_AW'(bx) + LN_AW'(LN_STRIDE) * LN_AW'(by);
        ln_data_d = red_pix;
        ready_d   = (bx == BXW'(OUT_W - 1)) && (by == BYW'(OUT_H - 1));
      end
      if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
      if (cur_x == X_LAST && cur_y == Y_LAST) begin
        state_d = ST_IDLE;
        x_d     = '0;
        y_d     = '0;
      end
      if (start) begin
        en_d   = enable;
        mode_d = ds_mode_e'(mode);
        thr_d  = bin_thr;
        err_d  = (state_q == ST_RUN);
      end
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      en_q        <= 1'b0;
      mode_q      <= MODE_AVG;
      thr_q       <= '0;
      disp_we_q   <= 1'b0;
      disp_addr_q <= '0;
      disp_data_q <= '0;
      ln_we_q     <= 1'b0;
      ln_addr_q   <= '0;
      ln_data_q   <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      en_q        <= en_d;
      mode_q      <= mode_d;
      thr_q       <= thr_d;
      disp_we_q   <= disp_we_d;
      disp_addr_q <= disp_addr_d;
      disp_data_q <= disp_data_d;
      ln_we_q     <= ln_we_d;
      ln_addr_q   <= ln_addr_d;
      ln_data_q   <= ln_data_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
    end
  end

  // A new SOF discards any partial blocks of an aborted frame.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_W; i++) lane_q[i] <= '0;
    end else begin
      if (start) begin
        for (int i = 0; i < OUT_W; i++) lane_q[i] <= '0;
      end
      if (lane_we) lane_q[bx] <= lane_d;
    end
  end

  assign disp_we    = disp_we_q;
  assign disp_addr  = disp_addr_q;
  assign disp_data  = disp_data_q;
  assign ln_we      = ln_we_q;
  assign ln_addr    = ln_addr_q;
  assign ln_data    = ln_data_q;
  assign data_ready = ready_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_cnn_frame_downscaler.sv
// tb/tb_cnn_frame_downscaler.sv - scoreboard bench for cnn_frame_downscaler on a reduced frame
module tb_cnn_frame_downscaler;

  localparam int W = 40, H = 30, BW = 4, BH = 4, OW = 6, OH = 5;
  localparam int LB = 66, LS = 8, LAW = 6;
  localparam int LEFT = (W - OW * BW) / 2;
  localparam int TOP  = (H - OH * BH) / 2;

  logic           clk25 = 1'b0;
  logic           rst_n = 1'b0;
  logic           pix_valid = 1'b0, pix_sof = 1'b0, enable = 1'b0, border_en = 1'b0;
  logic [7:0]     pix_data = '0, bin_thr = '0;
  logic [1:0]     mode = '0;
  logic           disp_we, ln_we, data_ready, frame_err;
  logic [18:0]    disp_addr;
  logic [7:0]     disp_data, ln_data;
  logic [LAW-1:0] ln_addr;

  typedef struct { logic [18:0] addr; logic [7:0] data; } disp_exp_t;
  typedef struct { logic [LAW-1:0] addr; logic [7:0] data; logic rdy; } ln_exp_t;

  disp_exp_t dq[$];
  ln_exp_t   lq[$];
  int total = 0, bad = 0;
  int disp_cnt = 0, ln_cnt = 0, rdy_cnt = 0, err_cnt = 0, first_ln = 0, last_ln = 0;
  logic [7:0] frame_pix [H][W];

  always #5 clk25 = ~clk25;

  cnn_frame_downscaler #(
    .WIDTH(W), .HEIGHT(H), .BLK_W(BW), .BLK_H(BH), .OUT_W(OW), .OUT_H(OH),
    .PIX_W(8), .LN_BASE(LB), .LN_STRIDE(LS), .LN_AW(LAW)
  ) dut (
    .clk25(clk25), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .enable(enable), .mode(mode), .bin_thr(bin_thr),
    .border_en(border_en), .disp_we(disp_we), .disp_addr(disp_addr),
    .disp_data(disp_data), .ln_we(ln_we), .ln_addr(ln_addr), .ln_data(ln_data),
    .data_ready(data_ready), .frame_err(frame_err)
  );

  always @(negedge clk25) begin
    disp_exp_t de;
    ln_exp_t   le;
    if (disp_we === 1'b1) begin
      disp_cnt++;
      total++;
      if (dq.size() == 0) begin
        bad++;
        $display("FAIL disp_extra: addr=%0d data=%h with nothing expected", disp_addr, disp_data);
      end else begin
        de = dq.pop_front();
        if (disp_addr !== de.addr || disp_data !== de.data) begin
          bad++;
          $display("FAIL disp_write: got addr=%0d data=%h, want addr=%0d data=%h",
                   disp_addr, disp_data, de.addr, de.data);
        end
      end
    end
    if (ln_we === 1'b1) begin
      if (ln_cnt == 0) first_ln = int'(ln_addr);
      last_ln = int'(ln_addr);
      ln_cnt++;
      if (data_ready === 1'b1) rdy_cnt++;
      total++;
      if (lq.size() == 0) begin
        bad++;
        $display("FAIL ln_extra: addr=%0d data=%h with nothing expected", ln_addr, ln_data);
      end else begin
        le = lq.pop_front();
        if (ln_addr !== le.addr || ln_data !== le.data || data_ready !== le.rdy) begin
          bad++;
          $display("FAIL ln_write: got addr=%0d data=%h rdy=%b, want addr=%0d data=%h rdy=%b",
                   ln_addr, ln_data, data_ready, le.addr, le.data, le.rdy);
        end
      end
    end else if (data_ready !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL ready_alone: data_ready=%b without ln_we, want 0", data_ready);
    end
    if (frame_err === 1'b1) err_cnt++;
  end

  function automatic bit in_win(input int x, input int y);
    return x >= LEFT && x < LEFT + OW * BW && y >= TOP && y < TOP + OH * BH;
  endfunction

  function automatic bit on_border(input int x, input int y);
    return in_win(x, y) && (x == LEFT || x == LEFT + OW * BW - 1 || y == TOP || y == TOP + OH * BH - 1);
  endfunction

  function automatic logic [7:0] model_block(input int bx, input int by, input int md, input int thr);
    int sum = 0, mx = 0, avg;
    for (int dy = 0; dy < BH; dy++)
      for (int dx = 0; dx < BW; dx++) begin
        int p;
        p = int'(frame_pix[TOP + by * BH + dy][LEFT + bx * BW + dx]);
        sum += p;
        if (p > mx) mx = p;
      end
    avg = (sum + (BW * BH) / 2) / (BW * BH);
    if (avg > 255) avg = 255;
    if (md == 1) return 8'(mx);
    if (md == 2) return (avg >= thr) ? 8'hFF : 8'h00;
    return 8'(avg);
  endfunction

  task automatic clear_counts();
    disp_cnt = 0; ln_cnt = 0; rdy_cnt = 0; err_cnt = 0;
  endtask

  task automatic run_frame(input logic en, input logic [1:0] md, input logic [7:0] thr,
                           input int gap, input int stop_after);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        disp_exp_t de;
        ln_exp_t   le;
        int bx, by;
        if (stop_after >= 0 && y * W + x >= stop_after) return;
        for (int g = 0; g < 4 && gap > 0 && int'($urandom_range(99)) < gap; g++) begin
          pix_data = 8'($urandom);
          @(posedge clk25); #1;
        end
        de.addr = 19'(y * W + x);
        de.data = (border_en && en && on_border(x, y)) ? 8'hFF : frame_pix[y][x];
        dq.push_back(de);
        if (en && in_win(x, y) && (x - LEFT) % BW == BW - 1 && (y - TOP) % BH == BH - 1) begin
          bx = (x - LEFT) / BW;
          by = (y - TOP) / BH;
          le.addr = LAW'(LB + bx + LS * by);
          le.data = model_block(bx, by, int'(md), int'(thr));
          le.rdy  = (bx == OW - 1 && by == OH - 1);
          lq.push_back(le);
        end
        if (x == 0 && y == 0) begin
          enable = en; mode = md; bin_thr = thr;
        end
        pix_valid = 1'b1;
        pix_sof   = (x == 0 && y == 0);
        pix_data  = frame_pix[y][x];
        @(posedge clk25); #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        enable    = 1'($urandom);
        mode      = 2'($urandom);
        bin_thr   = 8'($urandom);
      end
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clk25);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 8'hAA; enable = 1'b1;
    repeat (3) @(posedge clk25);
    #1;
    total++; if (disp_we !== 1'b0)    begin bad++; $display("FAIL rst_disp_we: got %b want 0", disp_we); end
    total++; if (disp_addr !== '0)    begin bad++; $display("FAIL rst_disp_addr: got %0d want 0", disp_addr); end
    total++; if (disp_data !== '0)    begin bad++; $display("FAIL rst_disp_data: got %h want 0", disp_data); end
    total++; if (ln_we !== 1'b0)      begin bad++; $display("FAIL rst_ln_we: got %b want 0", ln_we); end
    total++; if (ln_addr !== '0)      begin bad++; $display("FAIL rst_ln_addr: got %0d want 0", ln_addr); end
    total++; if (ln_data !== '0)      begin bad++; $display("FAIL rst_ln_data: got %h want 0", ln_data); end
    total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", data_ready); end
    total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL rst_err: got %b want 0", frame_err); end
    pix_valid = 1'b0; pix_sof = 1'b0;
    rst_n = 1'b1;
    @(posedge clk25); #1;
    // Pixels without SOF in IDLE must be dropped silently.
    clear_counts();
    repeat (5) begin
      pix_valid = 1'b1; pix_data = 8'($urandom);
      @(posedge clk25); #1;
    end
    pix_valid = 1'b0;
    drain();
    total++; if (disp_cnt != 0) begin bad++; $display("FAIL idle_drop: got %0d writes want 0", disp_cnt); end
  endtask

  task automatic test_avg_const();
    border_en = 1'b0;
    foreach (frame_pix[y, x]) frame_pix[y][x] = 8'h80;
    clear_counts();
    run_frame(1'b1, 2'd0, 8'h00, 0, -1);
    drain();
    total++; if (ln_cnt != OW * OH) begin bad++; $display("FAIL avg_count: got %0d want %0d", ln_cnt, OW * OH); end
    total++; if (first_ln != (LB % 64)) begin bad++; $display("FAIL avg_first_addr: got %0d want %0d", first_ln, LB % 64); end
    total++; if (last_ln != ((LB + OW - 1 + LS * (OH - 1)) % 64)) begin
      bad++; $display("FAIL avg_last_addr: got %0d want %0d", last_ln, (LB + OW - 1 + LS * (OH - 1)) % 64);
    end
    total++; if (rdy_cnt != 1) begin bad++; $display("FAIL avg_ready: got %0d want 1", rdy_cnt); end
    total++; if (dq.size() != 0 || lq.size() != 0) begin
      bad++; $display("FAIL avg_pending: got disp=%0d ln=%0d want 0", dq.size(), lq.size());
    end
  endtask

  task automatic test_max_single();
    foreach (frame_pix[y, x]) frame_pix[y][x] = 8'h00;
    frame_pix[TOP + 2][LEFT + 1] = 8'hFF;
    clear_counts();
    run_frame(1'b1, 2'd1, 8'h00, 0, -1);
    drain();
    total++; if (ln_cnt != OW * OH) begin bad++; $display("FAIL max_count: got %0d want %0d", ln_cnt, OW * OH); end
    total++; if (lq.size() != 0) begin bad++; $display("FAIL max_pending: got %0d want 0", lq.size()); end
  endtask

  task automatic test_bin_halves();
    foreach (frame_pix[y, x]) frame_pix[y][x] = (x < LEFT + OW * BW / 2) ? 8'h3F : 8'h41;
    for (int y = 0; y < H; y++) frame_pix[y][0] = 8'hFF;
    clear_counts();
    run_frame(1'b1, 2'd2, 8'h40, 0, -1);
    drain();
    total++; if (ln_cnt != OW * OH) begin bad++; $display("FAIL bin_count: got %0d want %0d", ln_cnt, OW * OH); end
    total++; if (lq.size() != 0) begin bad++; $display("FAIL bin_pending: got %0d want 0", lq.size()); end
  endtask

  task automatic test_gaps_ramp();
    foreach (frame_pix[y, x]) frame_pix[y][x] = 8'(x * 5 + y * 3);
    clear_counts();
    run_frame(1'b1, 2'd3, 8'h00, 30, -1);
    drain();
    total++; if (disp_cnt != W * H) begin bad++; $display("FAIL gap_disp: got %0d want %0d", disp_cnt, W * H); end
    total++; if (ln_cnt != OW * OH || rdy_cnt != 1) begin
      bad++; $display("FAIL gap_ln: got %0d/%0d want %0d/1", ln_cnt, rdy_cnt, OW * OH);
    end
  endtask

  task automatic test_border();
    border_en = 1'b1;
    foreach (frame_pix[y, x]) frame_pix[y][x] = 8'(16 + x);
    clear_counts();
    run_frame(1'b1, 2'd0, 8'h00, 0, -1);
    drain();
    border_en = 1'b0;
    total++; if (dq.size() != 0 || lq.size() != 0) begin
      bad++; $display("FAIL border_pending: got disp=%0d ln=%0d want 0", dq.size(), lq.size());
    end
  endtask

  task automatic test_abort();
    foreach (frame_pix[y, x]) frame_pix[y][x] = 8'(x ^ y);
    clear_counts();
    run_frame(1'b1, 2'd0, 8'h00, 0, 700);
    foreach (frame_pix[y, x]) frame_pix[y][x] = 8'(x * y);
    run_frame(1'b1, 2'd1, 8'h00, 0, -1);
    drain();
    total++; if (err_cnt != 1) begin bad++; $display("FAIL abort_err: got %0d pulses want 1", err_cnt); end
    total++; if (rdy_cnt != 1) begin bad++; $display("FAIL abort_ready: got %0d want 1", rdy_cnt); end
    total++; if (ln_cnt != 3 * OW + OW * OH) begin
      bad++; $display("FAIL abort_count: got %0d want %0d", ln_cnt, 3 * OW + OW * OH);
    end
  endtask

  task automatic test_back_to_back();
    foreach (frame_pix[y, x]) frame_pix[y][x] = 8'($urandom);
    clear_counts();
    run_frame(1'b1, 2'd0, 8'h00, 0, -1);
    run_frame(1'b1, 2'd2, 8'h70, 0, -1);
    drain();
    total++; if (err_cnt != 0) begin bad++; $display("FAIL b2b_err: got %0d want 0", err_cnt); end
    total++; if (rdy_cnt != 2 || ln_cnt != 2 * OW * OH) begin
      bad++; $display("FAIL b2b_count: got rdy=%0d ln=%0d want 2/%0d", rdy_cnt, ln_cnt, 2 * OW * OH);
    end
  endtask

  task automatic test_reset_midframe();
    foreach (frame_pix[y, x]) frame_pix[y][x] = 8'(y * 7 + x);
    run_frame(1'b1, 2'd0, 8'h00, 0, 600);
    @(negedge clk25); #1;
    rst_n = 1'b0;
    total++; if (dq.size() != 0 || lq.size() != 0) begin
      bad++; $display("FAIL mid_pending: got disp=%0d ln=%0d want 0", dq.size(), lq.size());
    end
    pix_valid = 1'b1; pix_data = 8'h55;
    repeat (2) @(posedge clk25);
    #1;
    total++; if (disp_we !== 1'b0 || disp_addr !== '0 || disp_data !== '0) begin
      bad++; $display("FAIL mid_rst_disp: got we=%b addr=%0d data=%h want 0", disp_we, disp_addr, disp_data);
    end
    total++; if (ln_we !== 1'b0 || ln_addr !== '0 || ln_data !== '0 || data_ready !== 1'b0 || frame_err !== 1'b0) begin
      bad++; $display("FAIL mid_rst_ln: got we=%b addr=%0d data=%h rdy=%b err=%b want 0",
                      ln_we, ln_addr, ln_data, data_ready, frame_err);
    end
    pix_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk25); #1;
    clear_counts();
    border_en = 1'b1;
    run_frame(1'b0, 2'd0, 8'h00, 0, -1);
    drain();
    border_en = 1'b0;
    total++; if (disp_cnt != W * H) begin bad++; $display("FAIL dis_disp: got %0d want %0d", disp_cnt, W * H); end
    total++; if (ln_cnt != 0 || rdy_cnt != 0) begin
      bad++; $display("FAIL dis_ln: got ln=%0d rdy=%0d want 0/0", ln_cnt, rdy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_avg_const();
    test_max_single();
    test_bin_halves();
    test_gaps_ramp();
    test_border();
    test_abort();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
